pricer_seq: RTL and testbench

- Job-level sequencer for the American-put binomial engine.
- Accepts a step-count command from the host and issues the one-cycle start pulse to the address generator.
- Times every backward-induction step and the pipeline drain, then issues the readout pulse.
- Captures the option value and presents it on a valid/ready result port. It sits between the host interface and the address-generator/datapath pair.

---
 rtl/pricer_seq.sv | 200 ++++++++++++++++++++
 tb/tb_pricer_seq.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pricer_seq.sv
// pricer_seq: job-level sequencer for the American-put binomial engine.
//
// Accepts a step-count command, pulses start to the address generator, times each
// backward-induction step (step i lasts max(i>>2, PIPE_MIN) cycles, i = n..1), waits out
// the pipeline drain, pulses readout, captures the root value and offers it on a
// valid/ready result port.
//
// Optional feature: define PRICER_SEQ_ABORT_EN to add the abort input, which returns any
// busy or DONE state to IDLE on the next edge and pulses err.
//
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   cmd_valid/cmd_ready   command handshake, cmd_n = number of tree steps
//   start                 one-cycle launch pulse to the address generator
//   n                     latched step count, stable for the whole job
//   readout               one-cycle readout pulse to the datapath
//   res_in                datapath root-node value
//   res_valid/res_ready   result handshake, res_data = captured result
//   busy                  job in flight (LAUNCH..WAITRD)
//   step_idx              current step index
//   cyc_count             cycles from LAUNCH to DONE entry, saturating
//   err                   one-cycle pulse on a rejected (or aborted) command
//   abort                 only with PRICER_SEQ_ABORT_EN
module pricer_seq #(
  parameter int unsigned DW         = 32,
  parameter int unsigned PIPE_MIN   = 30,
  parameter int unsigned PIPE_DEPTH = 30,
  parameter int unsigned RD_LAT     = 2,
  parameter int unsigned N_MIN      = 4,
  parameter int unsigned N_MAX      = 1023
) (
  input  logic          clk,
  input  logic          rst,
`ifdef PRICER_SEQ_ABORT_EN
  input  logic          abort,
`endif
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [15:0]   cmd_n,
  output logic          start,
  output logic [15:0]   n,
  output logic          readout,
  input  logic [DW-1:0] res_in,
  output logic          res_valid,
  input  logic          res_ready,
  output logic [DW-1:0] res_data,
  output logic          busy,
  output logic [15:0]   step_idx,
  output logic [31:0]   cyc_count,
  output logic          err
);

  typedef enum logic [2:0] {
    StIdle, StLaunch, StStep, StDrain, StRead, StWaitRd, StDone
  } state_e;

  state_e        state_q, state_d;
  logic [15:0]   cnt_q, cnt_d;
  logic [15:0]   step_q, step_d;
  logic [15:0]   n_q, n_d;
  logic [DW-1:0] data_q, data_d;
  logic [31:0]   cyc_q, cyc_d;
  logic          err_q, err_d;
  logic          start_q, start_d;
  logic          readout_q, readout_d;
  logic          abort_w;
  logic          accept;
  logic          legal;

`ifdef PRICER_SEQ_ABORT_EN
  assign abort_w = abort;
`else
  assign abort_w = 1'b0;
`endif

  // Cycles spent on step i: the datapath needs at least PIPE_MIN, wide rows need i/4.
  function automatic logic [15:0] step_len(input logic [15:0] i);
    logic [15:0] s;
    s = i >> 2;
    return (s > 16'(PIPE_MIN)) ? s : 16'(PIPE_MIN);
  endfunction

  assign cmd_ready = (state_q == StIdle) && !abort_w;
  assign accept    = cmd_valid && cmd_ready;
  assign legal     = ({16'd0, cmd_n} >= 32'(N_MIN)) && ({16'd0, cmd_n} <= 32'(N_MAX));

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    step_d    = step_q;
    n_d       = n_q;
    data_d    = data_q;
    cyc_d     = cyc_q;
    err_d     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          if (legal) begin
            n_d     = cmd_n;
            step_d  = cmd_n;
            state_d = StLaunch;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      StLaunch: begin
        cnt_d   = step_len(step_q);
        cyc_d   = 32'd1;
        state_d = StStep;
      end
      StStep: begin
        if (cnt_q == 16'd1) begin
          if (step_q == 16'd1) begin
            cnt_d   = 16'(PIPE_DEPTH);
            state_d = StDrain;
          end else begin
            step_d = step_q - 16'd1;
            cnt_d  = step_len(step_q - 16'd1);
          end
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      StDrain: begin
        if (cnt_q == 16'd1) state_d = StRead;
        else                cnt_d   = cnt_q - 16'd1;
      end
      StRead: begin
        cnt_d   = 16'(RD_LAT);
        state_d = StWaitRd;
      end
      StWaitRd: begin
        if (cnt_q == 16'd1) begin
          data_d  = res_in;
          state_d = StDone;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      StDone: begin
        if (res_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Count every cycle after LAUNCH up to DONE entry; LAUNCH itself reloads to 1.
    if ((state_q == StStep) || (state_q == StDrain) || (state_q == StRead) ||
        (state_q == StWaitRd)) begin
      if (cyc_q != 32'hFFFF_FFFF) cyc_d = cyc_q + 32'd1;
    end

    if (abort_w && (state_q != StIdle)) begin
      state_d = StIdle;
      data_d  = data_q;
      err_d   = 1'b1;
    end

    // Pulses are registered off the state so they can never glitch or overlap.
    start_d   = (state_q == StLaunch) && !abort_w;
    readout_d = (state_q == StRead) && !abort_w;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      step_q    <= '0;
      n_q       <= '0;
      data_q    <= '0;
      cyc_q     <= '0;
      err_q     <= 1'b0;
      start_q   <= 1'b0;
      readout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      step_q    <= step_d;
      n_q       <= n_d;
      data_q    <= data_d;
      cyc_q     <= cyc_d;
      err_q     <= err_d;
      start_q   <= start_d;
      readout_q <= readout_d;
    end
  end

  assign start     = start_q;
  assign readout   = readout_q;
  assign n         = n_q;
  assign res_data  = data_q;
  assign step_idx  = step_q;
  assign cyc_count = cyc_q;
  assign err       = err_q;
  assign res_valid = (state_q == StDone);
  assign busy      = (state_q == StLaunch) || (state_q == StStep) || (state_q == StDrain) ||
                     (state_q == StRead) || (state_q == StWaitRd);

endmodule

// File: tb/tb_pricer_seq.sv
// tb_pricer_seq: directed self-checking bench for pricer_seq with a result scoreboard.
module tb_pricer_seq;

  localparam int PIPE_MIN   = 30;
  localparam int PIPE_DEPTH = 30;
  localparam int RD_LAT     = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [15:0] cmd_n = '0;
  logic        start;
  logic [15:0] n;
  logic        readout;
  logic [31:0] res_in = '0;
  logic        res_valid;
  logic        res_ready = 1'b1;
  logic [31:0] res_data;
  logic        busy;
  logic [15:0] step_idx;
  logic [31:0] cyc_count;
  logic        err;
`ifdef PRICER_SEQ_ABORT_EN
  logic        abort = 1'b0;
`endif

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [31:0] data;
    int          lat;
  } exp_t;
  exp_t sb[$];

  pricer_seq dut (
    .clk       (clk),
    .rst       (rst),
`ifdef PRICER_SEQ_ABORT_EN
    .abort     (abort),
`endif
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_n     (cmd_n),
    .start     (start),
    .n         (n),
    .readout   (readout),
    .res_in    (res_in),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .busy      (busy),
    .step_idx  (step_idx),
    .cyc_count (cyc_count),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic int step_cycles(input int i);
    int s;
    s = i / 4;
    return (s > PIPE_MIN) ? s : PIPE_MIN;
  endfunction

  // Accept edge to res_valid rise.
  function automatic int job_lat(input int nn);
    int s;
    s = 0;
    for (int i = 1; i <= nn; i++) s += step_cycles(i);
    return 1 + s + PIPE_DEPTH + 1 + RD_LAT;
  endfunction

  // Runs one legal job; hold = cycles of res_ready low once res_valid is up.
  task automatic run_job(input int nn, input logic [31:0] data, input int hold);
    exp_t e;
    int   k, first_start, first_read, starts, reads, c120, ctop, lat;
    bit   overlap, n_stable, stable;
    logic [31:0] held;
    lat = job_lat(nn);
    e.data = data;
    e.lat  = lat;
    sb.push_back(e);
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_n     = 16'(nn);
    res_in    = data;
    res_ready = (hold == 0);
    @(posedge clk);
    #1;
    chk("accept_busy", busy, 1);
    chk("accept_cmd_ready", cmd_ready, 0);
    chk("accept_n", n, nn);
    cmd_n = 16'hFFFF;  // host scribbles on cmd_n while busy
    k = 0; first_start = -1; first_read = -1; starts = 0; reads = 0; c120 = 0; ctop = 0;
    overlap = 0; n_stable = 1;
    while (!res_valid && k < lat + 10) begin
      @(posedge clk);
      k++;
      #1;
      if (start) begin
        starts++;
        if (first_start < 0) first_start = k;
      end
      if (readout) begin
        reads++;
        if (first_read < 0) first_read = k;
      end
      if (start && readout) overlap = 1;
      if (n !== 16'(nn)) n_stable = 0;
      if (busy && step_idx == 16'd120) c120++;
      if (busy && first_start > 0 && step_idx == 16'(nn)) ctop++;
      if (k == 20) cmd_valid = 1'b0;
    end
    chk("res_valid_seen", res_valid, 1);
    e = sb.pop_front();
    chk("latency", k, e.lat);
    chk("res_data", res_data, e.data);
    chk("cyc_count", cyc_count, e.lat);
    chk("start_cycle", first_start, 1);
    chk("readout_cycle", first_read, e.lat - 2);
    chk("start_pulses", starts, 1);
    chk("readout_pulses", reads, 1);
    chk("pulse_overlap", overlap, 0);
    chk("n_stable", n_stable, 1);
    chk("top_step_len", ctop, step_cycles(nn));
    if (nn >= 120) chk("step120_len", c120, 30);
    if (hold > 0) begin
      held = res_data;
      stable = 1;
      repeat (hold) begin
        @(posedge clk);
        #1;
        if (res_valid !== 1'b1 || res_data !== held || cmd_ready !== 1'b0) stable = 0;
      end
      chk("backpressure_stable", stable, 1);
      @(negedge clk);
      res_ready = 1'b1;
    end
    @(posedge clk);
    #1;
    chk("done_to_idle_valid", res_valid, 0);
    chk("done_to_idle_ready", cmd_ready, 1);
  endtask

  task automatic reject(input int nn);
    int starts;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_n     = 16'(nn);
    @(posedge clk);
    #1;
    chk("reject_err", err, 1);
    chk("reject_ready", cmd_ready, 1);
    chk("reject_busy", busy, 0);
    @(negedge clk);
    cmd_valid = 1'b0;
    starts = 0;
    repeat (5) begin
      @(posedge clk);
      #1;
      if (start || busy || err) starts++;
    end
    chk("reject_quiet", starts, 0);
  endtask

  initial begin
    // Reset values, checked while reset is still asserted.
    #1;
    chk("rst_start", start, 0);
    chk("rst_readout", readout, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    chk("rst_n", n, 0);
    chk("rst_res_data", res_data, 0);
    chk("rst_step_idx", step_idx, 0);
    chk("rst_cyc_count", cyc_count, 0);
    chk("rst_cmd_ready", cmd_ready, 1);
    repeat (3) @(negedge clk);
    rst = 1'b0;

    reject(3);
    reject(1024);

    run_job(8, 32'h1234_5678, 0);
    run_job(200, 32'hCAFE_F00D, 0);
    run_job(4, 32'hA5A5_0001, 50);
    run_job(4, 32'h0BAD_BEEF, 0);

    // Asynchronous reset in the middle of a step.
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_n     = 16'd8;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    chk("midstep_busy", busy, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_start", start, 0);
    chk("midrst_readout", readout, 0);
    chk("midrst_res_valid", res_valid, 0);
    chk("midrst_cmd_ready", cmd_ready, 1);
    chk("midrst_step_idx", step_idx, 0);
    @(negedge clk);
    rst = 1'b0;
    run_job(8, 32'h7777_1111, 0);

`ifdef PRICER_SEQ_ABORT_EN
    begin
      int bad;
      @(negedge clk);
      cmd_valid = 1'b1;
      cmd_n     = 16'd8;
      res_in    = 32'hDEAD_0000;
      @(posedge clk);
      @(negedge clk);
      cmd_valid = 1'b0;
      repeat (1 + 240 + 5 - 1) @(posedge clk);  // now inside DRAIN
      @(negedge clk);
      abort = 1'b1;
      @(posedge clk);
      #1;
      chk("abort_busy", busy, 0);
      chk("abort_err", err, 1);
      chk("abort_res_data", res_data, 32'h7777_1111);
      @(negedge clk);
      abort = 1'b0;
      bad = 0;
      repeat (40) begin
        @(posedge clk);
        #1;
        if (readout || res_valid || busy) bad++;
      end
      chk("abort_no_readout", bad, 0);
      chk("abort_cmd_ready", cmd_ready, 1);
    end
`endif

    chk("scoreboard_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
